// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Write-back scheduler and scoreboard for the 16x16-bit register file.
// Two producers (ALU, load unit) share the single register-file write port
// through valid/ready handshakes and round-robin arbitration. A busy bit per
// register tracks outstanding writes so issue can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   flush               cancel all outstanding reservations
//   iss_valid/iss_rd    reservation request; iss_ready = accepted (comb)
//   chk_ra/chk_rb       source registers; chk_hazard = either busy (comb)
//   alu_valid/rd/data   ALU write-back request; alu_ready = grant (comb)
//   mem_valid/rd/data   load write-back request; mem_ready = grant (comb)
//   wen/sel_rd/wdata    registered register-file write port
//   busy                registered scoreboard, bit i = write to Ri pending
//   err                 sticky: a write-back hit a non-busy register
module regfile_wb_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        iss_valid,
  input  logic [3:0]  iss_rd,
  output logic        iss_ready,
  input  logic [3:0]  chk_ra,
  input  logic [3:0]  chk_rb,
  output logic        chk_hazard,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_rd,
  input  logic [15:0] mem_data,
  output logic        mem_ready,
  output logic        wen,
  output logic [3:0]  sel_rd,
  output logic [15:0] wdata,
  output logic [15:0] busy,
  output logic        err
);

  // Round-robin pointer: 0 favours ALU, 1 favours MEM under contention.
  logic        pri;

  logic        grantAlu;
  logic        grantMem;
  logic        xfer;
  logic [3:0]  xferRd;
  logic [15:0] xferData;
  logic [15:0] busyNext;

  // Arbitration: a lone requester always wins; otherwise pri decides.
  always_comb begin
    grantAlu = alu_valid & (~mem_valid | ~pri);
    grantMem = mem_valid & (~alu_valid | pri);
    xfer     = grantAlu | grantMem;
    xferRd   = grantAlu ? alu_rd   : mem_rd;
    xferData = grantAlu ? alu_data : mem_data;
  end

  assign alu_ready  = grantAlu;
  assign mem_ready  = grantMem;
  // A bit that is clearing this cycle still blocks reservation; issue retries.
  assign iss_ready  = iss_valid & ~busy[iss_rd] & ~flush;
  assign chk_hazard = busy[chk_ra] | busy[chk_rb];

  // Set and clear never collide: set needs a free bit, clear targets a busy one.
  always_comb begin
    busyNext = busy;
    if (wen)
      busyNext[sel_rd] = 1'b0;
    if (iss_ready)
      busyNext[iss_rd] = 1'b1;
    if (flush)
      busyNext = '0;
  end

  // Write stage: one granted transfer lands on the register-file port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pri    <= 1'b0;
      wen    <= 1'b0;
      sel_rd <= '0;
      wdata  <= '0;
      busy   <= '0;
      err    <= 1'b0;
    end else begin
      wen  <= xfer;
      busy <= busyNext;
      if (xfer) begin
        sel_rd <= xferRd;
        wdata  <= xferData;
        // Whoever won, the other producer is favoured next time.
        pri    <= grantAlu;
        if (!busy[xferRd])
          err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        iss_valid;
  logic [3:0]  iss_rd;
  logic        iss_ready;
  logic [3:0]  chk_ra;
  logic [3:0]  chk_rb;
  logic        chk_hazard;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        wen;
  logic [3:0]  sel_rd;
  logic [15:0] wdata;
  logic [15:0] busy;
  logic        err;

  int nTests = 0;
  int nFail  = 0;

  // Expected register-file writes, {rd, data}, in commit order.
  logic [19:0] expQ[$];

  regfile_wb_sched dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .chk_hazard(chk_hazard),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wen(wen), .sel_rd(sel_rd), .wdata(wdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Every write-port cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && wen === 1'b1) begin
      if (expQ.size() == 0) begin
        chk("unexpected_write", {12'h0, sel_rd, wdata}, 32'hFFFF_FFFF);
      end else begin
        logic [19:0] e;
        e = expQ.pop_front();
        chk("write_port", {12'h0, sel_rd, wdata}, {12'h0, e});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with every input active.
    rst = 1'b0; flush = 1'b0;
    iss_valid = 1'b1; iss_rd = 4'd3; chk_ra = 4'd3; chk_rb = 4'd0;
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 16'h2222;
    repeat (3) step();
    chk("rst_wen", wen, 1'b0);
    chk("rst_busy", busy, 16'h0000);
    chk("rst_err", err, 1'b0);
    chk("rst_selrd", sel_rd, 4'd0);
    chk("rst_wdata", wdata, 16'h0000);
    iss_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    rst = 1'b1;
    settle();
    chk("idle_alu_ready", alu_ready, 1'b0);
    alu_valid = 1'b1;
    settle();
    chk("lone_alu_ready", alu_ready, 1'b1);
    chk("lone_mem_ready", mem_ready, 1'b0);
    alu_valid = 1'b0;
    step();
    chk("no_write_after_rst", wen, 1'b0);

    // Reserve R3 then ALU writes BEEF.
    iss_valid = 1'b1; iss_rd = 4'd3;
    settle();
    chk("iss_r3_ready", iss_ready, 1'b1);
    step();
    iss_valid = 1'b0;
    chk("busy_r3", busy, 16'h0008);
    chk_ra = 4'd3;
    settle();
    chk("hazard_r3", chk_hazard, 1'b1);
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'hBEEF;
    settle();
    chk("alu_r3_ready", alu_ready, 1'b1);
    expQ.push_back({4'd3, 16'hBEEF});
    step();
    alu_valid = 1'b0;
    chk("wen_r3", wen, 1'b1);
    chk("selrd_r3", sel_rd, 4'd3);
    chk("wdata_r3", wdata, 16'hBEEF);
    chk("busy_r3_still", busy, 16'h0008);
    step();
    chk("busy_r3_clear", busy, 16'h0000);
    chk("hazard_r3_clear", chk_hazard, 1'b0);
    chk("wen_idle", wen, 1'b0);

    // WAW stall on R5.
    iss_valid = 1'b1; iss_rd = 4'd5;
    step();
    chk("busy_r5", busy, 16'h0020);
    settle();
    chk("waw_stall", iss_ready, 1'b0);
    mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 16'h1234;
    settle();
    chk("mem_r5_ready", mem_ready, 1'b1);
    expQ.push_back({4'd5, 16'h1234});
    step();
    mem_valid = 1'b0;
    settle();
    chk("waw_stall_clearing", iss_ready, 1'b0);
    step();
    chk("busy_r5_clear", busy, 16'h0000);
    chk("waw_retry_ready", iss_ready, 1'b1);
    step();
    iss_valid = 1'b0;
    chk("busy_r5_again", busy, 16'h0020);
    mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 16'h5555;
    expQ.push_back({4'd5, 16'h5555});
    step();
    mem_valid = 1'b0;
    step();
    chk("busy_r5_done", busy, 16'h0000);

    // Contention: ALU R1,R4 vs MEM R2,R6.
    iss_valid = 1'b1;
    iss_rd = 4'd1; step();
    iss_rd = 4'd2; step();
    iss_rd = 4'd4; step();
    iss_rd = 4'd6; step();
    iss_valid = 1'b0;
    chk("busy_contend", busy, 16'h0056);
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'hA001;
    mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 16'hB002;
    settle();
    chk("c1_alu_ready", alu_ready, 1'b1);
    chk("c1_mem_ready", mem_ready, 1'b0);
    expQ.push_back({4'd1, 16'hA001});
    step();
    alu_rd = 4'd4; alu_data = 16'hA004;
    settle();
    chk("c2_wen", wen, 1'b1);
    chk("c2_alu_ready", alu_ready, 1'b0);
    chk("c2_mem_ready", mem_ready, 1'b1);
    expQ.push_back({4'd2, 16'hB002});
    step();
    mem_rd = 4'd6; mem_data = 16'hB006;
    settle();
    chk("c3_wen", wen, 1'b1);
    chk("c3_alu_ready", alu_ready, 1'b1);
    chk("c3_mem_ready", mem_ready, 1'b0);
    expQ.push_back({4'd4, 16'hA004});
    step();
    alu_valid = 1'b0;
    settle();
    chk("c4_wen", wen, 1'b1);
    chk("c4_mem_ready", mem_ready, 1'b1);
    expQ.push_back({4'd6, 16'hB006});
    step();
    mem_valid = 1'b0;
    chk("c5_wen", wen, 1'b1);
    step();
    chk("contend_busy_clear", busy, 16'h0000);
    chk("contend_err", err, 1'b0);

    // Simultaneous clear of R7 and set of R9.
    iss_valid = 1'b1; iss_rd = 4'd7;
    step();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h7777;
    expQ.push_back({4'd7, 16'h7777});
    step();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 4'd9;
    settle();
    chk("setclr_iss_ready", iss_ready, 1'b1);
    step();
    iss_valid = 1'b0;
    chk("setclr_busy", busy, 16'h0200);
    alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 16'h9999;
    expQ.push_back({4'd9, 16'h9999});
    step();
    alu_valid = 1'b0;
    step();
    chk("setclr_done", busy, 16'h0000);
    chk("setclr_err", err, 1'b0);

    // Flush, then a late MEM write to R4 raises err.
    iss_valid = 1'b1;
    iss_rd = 4'd4; step();
    iss_rd = 4'd5; step();
    iss_rd = 4'd6; step();
    iss_rd = 4'd7; step();
    chk("busy_f0", busy, 16'h00F0);
    flush = 1'b1; iss_rd = 4'd2;
    settle();
    chk("flush_iss_ready", iss_ready, 1'b0);
    step();
    flush = 1'b0; iss_valid = 1'b0;
    chk("flush_busy", busy, 16'h0000);
    mem_valid = 1'b1; mem_rd = 4'd4; mem_data = 16'hCAFE;
    settle();
    chk("late_mem_ready", mem_ready, 1'b1);
    expQ.push_back({4'd4, 16'hCAFE});
    step();
    mem_valid = 1'b0;
    chk("late_err", err, 1'b1);
    chk("late_wen", wen, 1'b1);
    repeat (3) step();
    chk("err_sticky", err, 1'b1);
    chk("late_busy", busy, 16'h0000);

    // Reset mid-write discards the pending write and restores pri/err.
    alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 16'hDEAD;
    step();
    alu_valid = 1'b0;
    rst = 1'b0;
    settle();
    chk("midrst_wen", wen, 1'b0);
    chk("midrst_err", err, 1'b0);
    step();
    rst = 1'b1;
    alu_valid = 1'b1; mem_valid = 1'b1;
    settle();
    chk("rst_pri_alu", alu_ready, 1'b1);
    chk("rst_pri_mem", mem_ready, 1'b0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
    chk("postrst_wen", wen, 1'b0);
    step();

    chk("queue_drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
